csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
- Machine-mode CSR file and trap controller. Sits at the memory/writeback end of the pipeline.
- Consumes the registered CSR control (CSR_reg_wr, CSR_reg_rd, is_mret) together with the MW-stage PC, address and data.
- Performs CSR reads and writes, latches timer and external interrupts, and takes traps.
- Drives a PC redirect (epc_taken/epc_pc) back to fetch on interrupt entry and on mret.

Parameters:
- XLEN, 32, data and PC width.
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- CSR_reg_wr  input  1  MW-stage CSR write enable.
- CSR_reg_rd  input  1  MW-stage CSR read enable.
- is_mret  input  1  MW-stage instruction is mret.
- instr_valid  input  1  MW stage holds a real (non-bubble) instruction.
- csr_addr  input  12  CSR address.
- csr_wdata  input  XLEN  CSR write data.
- pc_mw  input  XLEN  PC of the MW-stage instruction.
- timer_irq  input  1  machine timer interrupt request, level.
- ext_irq  input  1  machine external interrupt request, level.
- csr_rdata  output  XLEN  CSR read data.
- epc_taken  output  1  redirect fetch this cycle.
- epc_pc  output  XLEN  redirect target.

Behaviour:
- Implemented CSRs and their reset values (reset low, asynchronous):
  - mstatus 0x300: MIE bit3, MPIE bit7, other bits read 0. Reset 0.
  - mie 0x304: MTIE bit7, MEIE bit11, others 0. Reset 0.
  - mtvec 0x305: reset MTVEC_RST.
  - mepc 0x341: bits[1:0] always 0. Reset 0.
  - mcause 0x342: reset 0.
  - mip 0x344: MTIP bit7, MEIP bit11, read-only. Reset 0.
- Output reset values: csr_rdata=0, epc_taken=0, epc_pc=0.
- Read:
  - Combinational. csr_rdata = selected CSR when CSR_reg_rd=1, else 0.
  - An unimplemented address reads 0 with no side effect.
- Write:
  - Occurs at the rising edge when CSR_reg_wr=1, instr_valid=1 and no trap is taken that cycle.
  - Only the implemented bits are stored.
  - Writes to mip or to an unimplemented address are ignored.
  - mtvec: bit1 is forced to 0, so mode is 00 (direct) or 01 (vectored).
  - mepc: bits[1:0] are forced to 0.
- Read-then-write to the same CSR in one cycle: csr_rdata returns the old value; the new value is visible the next cycle.
- mip sampling: MTIP/MEIP are registered from timer_irq/ext_irq every cycle, giving 1-cycle latency. Deassertion clears them the same way.
- Interrupt pending: irq_pend = mstatus.MIE & instr_valid & |(mie & mip).
- Interrupt priority: external (cause 11) over timer (cause 7).
- Trap entry, when irq_pend=1:
  - epc_taken=1 combinationally in that cycle.
  - epc_pc = {mtvec[XLEN-1:2],2'b00} in direct mode; that base + 4*cause in vectored mode.
  - At the edge: mepc<=pc_mw, mcause<={1'b1, cause}, MPIE<=MIE, MIE<=0.
  - The MW instruction is considered not executed: any CSR write and any mret that cycle are suppressed.
- mret, when is_mret=1, instr_valid=1 and irq_pend=0:
  - epc_taken=1 and epc_pc=mepc in that cycle.
  - At the edge: MIE<=MPIE, MPIE<=1.
- One trap per cycle at most. While MIE=0 after entry, no nested interrupt is taken.
- Reset asserted mid-operation: all state clears immediately and epc_taken drops asynchronously. Any pending trap is lost.
- Bubble (instr_valid=0): no write, no mret, no trap. Outputs remain combinational on the current state.

Test Plan:
- Reset, then read every implemented address -> csr_rdata = 0, except mtvec = MTVEC_RST. Address 0x7C0 -> 0.
- Write mtvec=0x0000_1003, then read -> 0x0000_1001. Write mepc=0x0000_0107, then read -> 0x0000_0104. Write mip=0xFFFF_FFFF -> mip stays 0.
- mstatus=0x8, mie=0x80, timer_irq rises with pc_mw=0x200, mtvec=0x100 (direct):
  - Next cycle -> epc_taken=1, epc_pc=0x100.
  - After the edge -> mepc=0x200, mcause=0x8000_0007, mstatus=0x80.
- Vectored mtvec=0x101, both irqs pending with MEIE|MTIE enabled -> epc_pc=0x12C, mcause=0x8000_000B.
- mret after a trap, with mepc=0x200 -> epc_taken=1, epc_pc=0x200, mstatus=0x88 next cycle. Repeat with an interrupt pending in the same cycle as mret -> trap wins, mepc=pc_mw of the mret.
- CSR write to mie in the same cycle as a taken trap -> mie unchanged. Assert reset while epc_taken=1 -> epc_taken=0 immediately and all CSRs reset.

Source files
------------

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file and trap controller at the MW stage
// Reads are combinational; writes, trap entry and mret take effect at the clock edge.
module csr_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            CSR_reg_wr,
  input  logic            CSR_reg_rd,
  input  logic            is_mret,
  input  logic            instr_valid,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] pc_mw,
  input  logic            timer_irq,
  input  logic            ext_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            epc_taken,
  output logic [XLEN-1:0] epc_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic            r_mie_mtie;
  logic            r_mie_meie;
  logic            r_mip_mtip;
  logic            r_mip_meip;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;

  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mie;
  logic [XLEN-1:0] w_mip;
  logic [XLEN-1:0] w_rdata;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap_pc;
  logic [3:0]      w_cause;
  logic            w_ext_act;
  logic            w_tmr_act;
  logic            w_irq_pend;
  logic            w_mret_go;
  logic            w_wr_go;

  always_comb begin
    w_mstatus     = '0;
    w_mstatus[3]  = r_mstatus_mie;
    w_mstatus[7]  = r_mstatus_mpie;
    w_mie         = '0;
    w_mie[7]      = r_mie_mtie;
    w_mie[11]     = r_mie_meie;
    w_mip         = '0;
    w_mip[7]      = r_mip_mtip;
    w_mip[11]     = r_mip_meip;
  end

  assign w_ext_act  = r_mie_meie & r_mip_meip;
  assign w_tmr_act  = r_mie_mtie & r_mip_mtip;
  assign w_irq_pend = r_mstatus_mie & instr_valid & (w_ext_act | w_tmr_act);
  assign w_cause    = w_ext_act ? 4'd11 : 4'd7;
  assign w_mret_go  = is_mret & instr_valid & ~w_irq_pend;
  assign w_wr_go    = CSR_reg_wr & instr_valid & ~w_irq_pend;

  // Vectored mode offsets the base by 4*cause; direct mode jumps to the base.
  assign w_base    = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_trap_pc = w_base + (r_mtvec[0] ? {{(XLEN-6){1'b0}}, w_cause, 2'b00} : '0);

  always_comb begin
    w_rdata = '0;
    if (CSR_reg_rd) begin
      case (csr_addr)
        ADDR_MSTATUS: w_rdata = w_mstatus;
        ADDR_MIE:     w_rdata = w_mie;
        ADDR_MTVEC:   w_rdata = r_mtvec;
        ADDR_MEPC:    w_rdata = r_mepc;
        ADDR_MCAUSE:  w_rdata = r_mcause;
        ADDR_MIP:     w_rdata = w_mip;
        default:      w_rdata = '0;
      endcase
    end
  end

  // Outputs are gated by reset so a redirect drops the moment reset asserts.
  assign csr_rdata = reset ? w_rdata : '0;
  assign epc_taken = reset & (w_irq_pend | w_mret_go);
  assign epc_pc    = !reset    ? '0 :
                     w_irq_pend ? w_trap_pc :
                     w_mret_go  ? r_mepc : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_mtie     <= 1'b0;
      r_mie_meie     <= 1'b0;
      r_mip_mtip     <= 1'b0;
      r_mip_meip     <= 1'b0;
      r_mtvec        <= MTVEC_RST;
      r_mepc         <= '0;
      r_mcause       <= '0;
    end else begin
      r_mip_mtip <= timer_irq;
      r_mip_meip <= ext_irq;
      if (w_irq_pend) begin
        r_mepc         <= {pc_mw[XLEN-1:2], 2'b00};
        r_mcause       <= {1'b1, {(XLEN-5){1'b0}}, w_cause};
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else begin
        if (w_wr_go) begin
          case (csr_addr)
            ADDR_MSTATUS: begin
              r_mstatus_mie  <= csr_wdata[3];
              r_mstatus_mpie <= csr_wdata[7];
            end
            ADDR_MIE: begin
              r_mie_mtie <= csr_wdata[7];
              r_mie_meie <= csr_wdata[11];
            end
            ADDR_MTVEC:  r_mtvec  <= {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
            ADDR_MEPC:   r_mepc   <= {csr_wdata[XLEN-1:2], 2'b00};
            ADDR_MCAUSE: r_mcause <= csr_wdata;
            default: ;
          endcase
        end
        if (w_mret_go) begin
          r_mstatus_mie  <= r_mstatus_mpie;
          r_mstatus_mpie <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - self-checking bench for csr_unit
// Directed vector table, a reset-during-trap sequence, then random cycles against a model.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        CSR_reg_wr = 1'b0;
  logic        CSR_reg_rd = 1'b0;
  logic        is_mret = 1'b0;
  logic        instr_valid = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] pc_mw = '0;
  logic        timer_irq = 1'b0;
  logic        ext_irq = 1'b0;
  logic [31:0] csr_rdata;
  logic        epc_taken;
  logic [31:0] epc_pc;

  int checks = 0;
  int failures = 0;

  csr_unit #(.XLEN(32), .MTVEC_RST(32'h0)) dut (
    .clk(clk), .reset(reset), .CSR_reg_wr(CSR_reg_wr), .CSR_reg_rd(CSR_reg_rd),
    .is_mret(is_mret), .instr_valid(instr_valid), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .pc_mw(pc_mw), .timer_irq(timer_irq), .ext_irq(ext_irq),
    .csr_rdata(csr_rdata), .epc_taken(epc_taken), .epc_pc(epc_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr, rd, mret, valid;
    logic [11:0] addr;
    logic [31:0] wdata, pc;
    logic        t, e;
    logic [31:0] er;
    logic        et;
    logic [31:0] ep;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic wr, logic rd, logic mret, logic valid, logic [11:0] addr,
                              logic [31:0] wdata, logic [31:0] pc, logic t, logic e,
                              logic [31:0] er, logic et, logic [31:0] ep);
    vec_t v;
    v.wr = wr; v.rd = rd; v.mret = mret; v.valid = valid; v.addr = addr; v.wdata = wdata;
    v.pc = pc; v.t = t; v.e = e; v.er = er; v.et = et; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic mret, input logic valid,
                       input logic [11:0] addr, input logic [31:0] wdata, input logic [31:0] pc,
                       input logic t, input logic e);
    CSR_reg_wr = wr; CSR_reg_rd = rd; is_mret = mret; instr_valid = valid;
    csr_addr = addr; csr_wdata = wdata; pc_mw = pc; timer_irq = t; ext_irq = e;
  endtask

  task automatic read_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    drive(1'b0, 1'b1, 1'b0, 1'b0, addr, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk(name, csr_rdata, exp);
    @(negedge clk);
  endtask

  // Reference model: whole-register values with masks.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mip;

  function automatic logic [31:0] m_read(logic rd, logic [11:0] addr);
    if (!rd) return 32'h0;
    case (addr)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_pend(logic valid);
    return m_mstatus[3] && valid && ((m_mie & m_mip) != 0);
  endfunction

  function automatic int m_cause();
    return ((m_mie & m_mip & 32'h800) != 0) ? 11 : 7;
  endfunction

  function automatic logic [31:0] m_target(logic valid, logic mret);
    if (m_pend(valid)) return (m_mtvec & ~32'h3) + (m_mtvec[0] ? 32'(4 * m_cause()) : 32'h0);
    if (mret && valid) return m_mepc;
    return 32'h0;
  endfunction

  task automatic m_update(input logic wr, input logic mret, input logic valid, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc, input logic t, input logic e);
    logic [31:0] nip;
    nip = (t ? 32'h80 : 32'h0) | (e ? 32'h800 : 32'h0);
    if (m_pend(valid)) begin
      m_mepc    = pc & ~32'h3;
      m_mcause  = 32'h8000_0000 | 32'(m_cause());
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    end else begin
      if (wr && valid) begin
        case (addr)
          12'h300: m_mstatus = wdata & 32'h88;
          12'h304: m_mie     = wdata & 32'h880;
          12'h305: m_mtvec   = wdata & ~32'h2;
          12'h341: m_mepc    = wdata & ~32'h3;
          12'h342: m_mcause  = wdata;
          default: ;
        endcase
      end
      if (mret && valid) m_mstatus = (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
    end
    m_mip = nip;
  endtask

  initial begin
    // wr rd mret valid addr wdata pc t e | exp_rdata exp_taken exp_pc
    tbl.push_back(mk(0,1,0,1,12'h300,0,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,1,0,1,12'h304,0,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,1,0,1,12'h305,0,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,1,0,1,12'h341,0,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,1,0,1,12'h342,0,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,1,0,1,12'h344,0,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,1,0,1,12'h7C0,0,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(1,1,0,1,12'h305,32'h1003,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,1,0,1,12'h305,0,0,0,0, 32'h1001,0,0));
    tbl.push_back(mk(1,0,0,1,12'h341,32'h107,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,1,0,1,12'h341,0,0,0,0, 32'h104,0,0));
    tbl.push_back(mk(1,0,0,1,12'h344,32'hFFFF_FFFF,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,1,0,1,12'h344,0,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(1,0,0,1,12'h305,32'h100,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(1,0,0,1,12'h304,32'h80,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(1,0,0,1,12'h300,32'h8,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,1,0,1,12'h305,0,32'h200,1,0, 32'h100,0,0));
    tbl.push_back(mk(0,1,0,1,12'h300,0,32'h200,1,0, 32'h8,1,32'h100));
    tbl.push_back(mk(0,1,0,1,12'h341,0,0,1,0, 32'h200,0,0));
    tbl.push_back(mk(0,1,0,1,12'h342,0,0,1,0, 32'h8000_0007,0,0));
    tbl.push_back(mk(0,1,0,1,12'h300,0,0,1,0, 32'h80,0,0));
    tbl.push_back(mk(0,1,0,1,12'h344,0,0,1,0, 32'h80,0,0));
    tbl.push_back(mk(0,0,1,1,12'h000,0,32'h240,0,0, 32'h0,1,32'h200));
    tbl.push_back(mk(0,1,0,1,12'h300,0,0,0,0, 32'h88,0,0));
    tbl.push_back(mk(1,0,0,1,12'h305,32'h101,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(1,0,0,1,12'h304,32'h880,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,0,0,1,12'h000,0,32'h300,1,1, 32'h0,0,0));
    tbl.push_back(mk(0,0,0,1,12'h000,0,32'h300,1,1, 32'h0,1,32'h12C));
    tbl.push_back(mk(0,1,0,1,12'h342,0,0,0,0, 32'h8000_000B,0,0));
    tbl.push_back(mk(1,0,0,1,12'h300,32'h88,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,1,0,0,12'h300,0,0,1,0, 32'h88,0,0));
    tbl.push_back(mk(0,0,1,1,12'h000,0,32'h400,1,0, 32'h0,1,32'h11C));
    tbl.push_back(mk(0,1,0,1,12'h341,0,0,0,0, 32'h400,0,0));
    tbl.push_back(mk(0,1,0,1,12'h300,0,0,0,0, 32'h80,0,0));
    tbl.push_back(mk(1,0,0,1,12'h300,32'h8,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,0,0,1,12'h000,0,0,1,0, 32'h0,0,0));
    tbl.push_back(mk(1,0,0,1,12'h304,32'h0,32'h500,1,0, 32'h0,1,32'h11C));
    tbl.push_back(mk(0,1,0,1,12'h304,0,0,0,0, 32'h880,0,0));
    tbl.push_back(mk(0,1,0,1,12'h341,0,0,0,0, 32'h500,0,0));

    drive(0,0,0,0,12'h0,0,0,0,0);
    reset = 1'b0;
    #1;
    chk("rst_rdata", csr_rdata, 32'h0);
    chk("rst_taken", {31'h0, epc_taken}, 32'h0);
    chk("rst_pc", epc_pc, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].mret, tbl[i].valid, tbl[i].addr, tbl[i].wdata,
            tbl[i].pc, tbl[i].t, tbl[i].e);
      #1;
      chk($sformatf("vec%0d_rdata", i), csr_rdata, tbl[i].er);
      chk($sformatf("vec%0d_taken", i), {31'h0, epc_taken}, {31'h0, tbl[i].et});
      chk($sformatf("vec%0d_pc", i), epc_pc, tbl[i].ep);
      @(negedge clk);
    end

    // Reset while a trap redirect is being driven.
    drive(1,0,0,1,12'h300,32'h8,0,0,0);
    @(negedge clk);
    drive(0,0,0,1,12'h000,0,0,1,0);
    @(negedge clk);
    drive(0,0,0,1,12'h000,0,32'h600,1,0);
    #1;
    chk("pre_rst_taken", {31'h0, epc_taken}, 32'h1);
    chk("pre_rst_pc", epc_pc, 32'h11C);
    reset = 1'b0;
    #1;
    chk("mid_rst_taken", {31'h0, epc_taken}, 32'h0);
    chk("mid_rst_pc", epc_pc, 32'h0);
    drive(0,0,0,0,12'h000,0,0,0,0);
    @(negedge clk);
    reset = 1'b1;
    read_chk("post_rst_mstatus", 12'h300, 32'h0);
    read_chk("post_rst_mie", 12'h304, 32'h0);
    read_chk("post_rst_mtvec", 12'h305, 32'h0);
    read_chk("post_rst_mepc", 12'h341, 32'h0);
    read_chk("post_rst_mcause", 12'h342, 32'h0);
    read_chk("post_rst_mip", 12'h344, 32'h0);

    // Randomized phase against the model.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mip = 0;
    begin
      logic [11:0] addrs [7];
      logic t, e;
      addrs[0] = 12'h300; addrs[1] = 12'h304; addrs[2] = 12'h305; addrs[3] = 12'h341;
      addrs[4] = 12'h342; addrs[5] = 12'h344; addrs[6] = 12'h7C0;
      t = 1'b0; e = 1'b0;
      for (int n = 0; n < 500; n++) begin
        logic wr, rd, mret, valid;
        logic [11:0] addr;
        logic [31:0] wdata, pc;
        valid = ($urandom_range(99) < 85);
        rd    = ($urandom_range(99) < 60);
        wr    = ($urandom_range(99) < 35);
        mret  = !wr && ($urandom_range(99) < 10);
        addr  = addrs[$urandom_range(6)];
        wdata = $urandom;
        pc    = $urandom;
        if ($urandom_range(99) < 15) t = ~t;
        if ($urandom_range(99) < 10) e = ~e;
        drive(wr, rd, mret, valid, addr, wdata, pc, t, e);
        #1;
        chk($sformatf("rnd%0d_rdata", n), csr_rdata, m_read(rd, addr));
        chk($sformatf("rnd%0d_taken", n), {31'h0, epc_taken},
            {31'h0, (m_pend(valid) || (mret && valid))});
        chk($sformatf("rnd%0d_pc", n), epc_pc, m_target(valid, mret));
        @(posedge clk);
        m_update(wr, mret, valid, addr, wdata, pc, t, e);
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
